// File: rtl/sweep_phase_gen_if.sv
// Sample/config bus between a controller and sweep_phase_gen, and the phase
// stream toward the downstream sintable stage.
interface sweep_phase_gen_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned PW = 17
);
  logic          i_ce;
  logic          i_wr;
  logic [1:0]    i_addr;
  logic [AW-1:0] i_data;
  logic [PW-1:0] o_phase;
  logic          o_ce;
  logic          o_aux;
  logic          o_done;

  modport master (
    output i_ce, i_wr, i_addr, i_data,
    input  o_phase, o_ce, o_aux, o_done
  );

  modport slave (
    input  i_ce, i_wr, i_addr, i_data,
    output o_phase, o_ce, o_aux, o_done
  );
endinterface

// File: rtl/sweep_phase_gen.sv
// Phase accumulator with fixed-tone and linear-chirp modes; the phase, strobe
// and wrap flag feed sintable's i_phase/i_ce/i_aux directly.
module sweep_phase_gen #(
  parameter int unsigned AW = 32,
  parameter int unsigned PW = 17
) (
  input  logic              i_clk,
  input  logic              i_reset,
  sweep_phase_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, TONE, SWEEP} state_t;

  state_t        state_q;
  logic [AW-1:0] fstart_q, fstop_q, fdelta_q;
  logic [2:0]    ctrl_q;
  logic [AW-1:0] acc_q, freq_q;
  logic [PW-1:0] phase_q;
  logic          ce_q, aux_q, done_q;

  logic [AW:0]   acc_sum;
  logic [AW:0]   freq_nxt;
  logic          ctrl_wr;

  always_comb begin
    acc_sum  = {1'b0, acc_q} + {1'b0, freq_q};
    freq_nxt = {1'b0, freq_q} + {1'b0, fdelta_q};
    ctrl_wr  = bus.i_wr && (bus.i_addr == 2'd3);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      fstart_q <= '0;
      fstop_q  <= '0;
      fdelta_q <= '0;
      ctrl_q   <= '0;
      acc_q    <= '0;
      freq_q   <= '0;
      phase_q  <= '0;
      ce_q     <= 1'b0;
      aux_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ce_q   <= 1'b0;
      aux_q  <= 1'b0;
      done_q <= 1'b0;

      if (bus.i_wr) begin
        unique case (bus.i_addr)
          2'd0: begin
            fstart_q <= bus.i_data;
            // Phase-continuous retune: only the increment changes in TONE
            if (state_q == TONE && !ctrl_wr) freq_q <= bus.i_data;
          end
          2'd1: fstop_q  <= bus.i_data;
          2'd2: fdelta_q <= bus.i_data;
          2'd3: ctrl_q   <= bus.i_data[2:0];
          default: ;
        endcase
      end

      // A CTRL write pre-empts any strobe arriving in the same cycle
      if (ctrl_wr) begin
        acc_q <= '0;
        if (bus.i_data[0]) begin
          freq_q  <= fstart_q;
          state_q <= bus.i_data[1] ? SWEEP : TONE;
        end else begin
          freq_q  <= '0;
          phase_q <= '0;
          state_q <= IDLE;
        end
      end else if (state_q != IDLE && bus.i_ce && ctrl_q[0]) begin
        acc_q   <= acc_sum[AW-1:0];
        phase_q <= acc_sum[AW-1 -: PW];
        ce_q    <= 1'b1;
        aux_q   <= acc_sum[AW];
        if (state_q == SWEEP && ctrl_q[1]) begin
          if (freq_nxt < {1'b0, fstop_q}) begin
            freq_q <= freq_nxt[AW-1:0];
          end else begin
            done_q <= 1'b1;
            if (ctrl_q[2]) begin
              freq_q <= fstart_q;
            end else begin
              freq_q  <= fstop_q;
              state_q <= TONE;
            end
          end
        end
      end
    end
  end

  assign bus.o_phase = phase_q;
  assign bus.o_ce    = ce_q;
  assign bus.o_aux   = aux_q;
  assign bus.o_done  = done_q;

endmodule
